// File: rtl/residual_pkg.sv
// Shared definitions for the residual_block write/read-side packers:
// packer state encoding and tensor size helpers.
package residual_pkg;

   typedef enum logic {
      FILL = 1'b0,
      FULL = 1'b1
   } pack_state_e;

   function automatic int calc_in_size(input int channels, input int height, input int width);
      return channels * height * width;
   endfunction

   // One extra count value so a completed tensor can report IN_SIZE.
   function automatic int calc_cnt_w(input int size);
      return $clog2(size + 1);
   endfunction

endpackage

// File: rtl/tensor_stream_packer.sv
// Streams elements into a flat channel-major/row/column tensor bus with a valid/ready handoff.
// Optional s_last framing check is enabled by defining TENSOR_LAST_CHECK_EN.
module tensor_stream_packer
   import residual_pkg::*;
#(
   parameter int DATA_WIDTH  = 8,
   parameter int IN_CHANNELS = 1,
   parameter int IN_HEIGHT   = 4,
   parameter int IN_WIDTH    = 4,
   localparam int IN_SIZE    = calc_in_size(IN_CHANNELS, IN_HEIGHT, IN_WIDTH),
   localparam int CNT_W      = calc_cnt_w(IN_SIZE)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic                          s_valid,
   output logic                          s_ready,
   input  logic signed [DATA_WIDTH-1:0]  s_data,
   output logic [IN_SIZE*DATA_WIDTH-1:0] tensor_flat,
   output logic                          tensor_valid,
   input  logic                          tensor_ready,
   output logic [CNT_W-1:0]              fill_count
`ifdef TENSOR_LAST_CHECK_EN
   ,
   input  logic                          s_last,
   output logic                          err_last
`endif
);

   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(IN_SIZE - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(IN_SIZE);

   pack_state_e      state_q;
   logic             s_ready_q;
   logic             tensor_valid_q;
   logic [CNT_W-1:0] fill_q;

   logic accept_d;
   logic last_beat_d;
   logic drop_d;
   logic slot_we_d;

   assign accept_d    = s_valid && s_ready_q && (state_q == FILL);
   assign last_beat_d = (fill_q == LAST_IDX);

`ifdef TENSOR_LAST_CHECK_EN
   logic err_last_q;
   logic err_d;

   // Early last drops the beat and restarts framing; missing last still completes.
   assign drop_d   = accept_d && s_last && !last_beat_d;
   assign err_d    = accept_d && (s_last != last_beat_d);
   assign err_last = err_last_q;
`else
   assign drop_d   = 1'b0;
`endif

   assign slot_we_d = accept_d && !drop_d;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q        <= FILL;
         fill_q         <= '0;
         s_ready_q      <= 1'b0;
         tensor_valid_q <= 1'b0;
`ifdef TENSOR_LAST_CHECK_EN
         err_last_q     <= 1'b0;
`endif
      end else begin
`ifdef TENSOR_LAST_CHECK_EN
         err_last_q <= err_d;
`endif
         case (state_q)
            FILL: begin
               s_ready_q      <= 1'b1;
               tensor_valid_q <= 1'b0;
               if (accept_d) begin
                  if (drop_d) begin
                     fill_q <= '0;
                  end else if (last_beat_d) begin
                     state_q        <= FULL;
                     fill_q         <= FULL_CNT;
                     s_ready_q      <= 1'b0;
                     tensor_valid_q <= 1'b1;
                  end else begin
                     fill_q <= fill_q + CNT_W'(1);
                  end
               end
            end
            FULL: begin
               if (tensor_ready) begin
                  state_q        <= FILL;
                  fill_q         <= '0;
                  s_ready_q      <= 1'b1;
                  tensor_valid_q <= 1'b0;
               end
            end
         endcase
      end
   end

   // Slots are only rewritten as new elements arrive, so the bus stays stable while FULL.
   for (genvar gi = 0; gi < IN_SIZE; gi++) begin : g_slot
      logic [DATA_WIDTH-1:0] slot_q;

      always_ff @(posedge clk or negedge rst) begin
         if (!rst) begin
            slot_q <= '0;
         end else if (slot_we_d && (fill_q == CNT_W'(gi))) begin
            slot_q <= s_data;
         end
      end

      assign tensor_flat[gi*DATA_WIDTH +: DATA_WIDTH] = slot_q;
   end

   assign s_ready      = s_ready_q;
   assign tensor_valid = tensor_valid_q;
   assign fill_count   = fill_q;

endmodule

// File: tb/tb_tensor_stream_packer.sv
// Directed bench for tensor_stream_packer at default parameters (8-bit, 16 elements).
module tb_tensor_stream_packer;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         s_valid = 1'b0;
   logic         s_ready;
   logic [7:0]   s_data = 8'h00;
   logic [127:0] tensor_flat;
   logic         tensor_valid;
   logic         tensor_ready = 1'b0;
   logic [4:0]   fill_count;
`ifdef TENSOR_LAST_CHECK_EN
   logic         s_last = 1'b0;
   logic         err_last;
`endif

   int pass_cnt  = 0;
   int total_cnt = 0;

   typedef struct {
      logic       v;
      logic [7:0] d;
      logic       tr;
      logic       exp_sr;
      logic       exp_tv;
      logic [4:0] exp_fill;
   } vec_t;

   vec_t tbl[16];

   tensor_stream_packer dut (
      .clk          (clk),
      .rst          (rst),
      .s_valid      (s_valid),
      .s_ready      (s_ready),
      .s_data       (s_data),
      .tensor_flat  (tensor_flat),
      .tensor_valid (tensor_valid),
      .tensor_ready (tensor_ready),
      .fill_count   (fill_count)
`ifdef TENSOR_LAST_CHECK_EN
      ,
      .s_last       (s_last),
      .err_last     (err_last)
`endif
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      logic [127:0] exp_flat;
      logic [127:0] old_flat;
      int           vals[16];
      int           idx;
      int           cyc;
      int           hi_cnt;
      int           last_hi;
      logic         prev_tv;

      vals = '{-128, -1, 127, 0, 1, -2, 64, -64, 100, -100, 85, -86, 2, -3, 126, -127};

      for (int i = 0; i < 16; i++) begin
         tbl[i].v        = 1'b1;
         tbl[i].d        = 8'(i);
         tbl[i].tr       = (i < 15) ? 1'(i % 2) : 1'b0;
         tbl[i].exp_sr   = (i != 15);
         tbl[i].exp_tv   = (i == 15);
         tbl[i].exp_fill = 5'(i + 1);
      end

      // Reset state
      repeat (3) step();
      chk("rst_s_ready", 128'(s_ready), 128'(0));
      chk("rst_tvalid", 128'(tensor_valid), 128'(0));
      chk("rst_fill", 128'(fill_count), 128'(0));
      chk("rst_flat", tensor_flat, 128'(0));
      rst = 1'b1;
      #1;
      chk("release_s_ready_before_edge", 128'(s_ready), 128'(0));
      step();
      chk("release_s_ready", 128'(s_ready), 128'(1));

      // Case 1: table-driven 0..15
      exp_flat = '0;
      for (int i = 0; i < 16; i++) begin
         s_valid      = tbl[i].v;
         s_data       = tbl[i].d;
         tensor_ready = tbl[i].tr;
         step();
         chk($sformatf("c1_fill_%0d", i), 128'(fill_count), 128'(tbl[i].exp_fill));
         chk($sformatf("c1_tv_%0d", i), 128'(tensor_valid), 128'(tbl[i].exp_tv));
         chk($sformatf("c1_sr_%0d", i), 128'(s_ready), 128'(tbl[i].exp_sr));
         exp_flat[i*8 +: 8] = tbl[i].d;
      end
      chk("c1_flat", tensor_flat, exp_flat);

      // Case 2: held in FULL, incoming beats ignored
      s_valid = 1'b1;
      s_data  = 8'hAA;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("c2_flat_%0d", i), tensor_flat, exp_flat);
         chk($sformatf("c2_fill_%0d", i), 128'(fill_count), 128'(16));
         chk($sformatf("c2_tv_%0d", i), 128'(tensor_valid), 128'(1));
      end
      s_valid      = 1'b0;
      tensor_ready = 1'b1;
      step();
      tensor_ready = 1'b0;
      chk("c2_drain_tv", 128'(tensor_valid), 128'(0));
      chk("c2_drain_sr", 128'(s_ready), 128'(1));
      chk("c2_drain_fill", 128'(fill_count), 128'(0));
      chk("c2_drain_flat_kept", tensor_flat, exp_flat);

      // Case 3: signed extremes with random gaps
      idx = 0;
      cyc = 0;
      exp_flat = '0;
      while (idx < 16 && cyc < 400) begin
         s_valid = ($urandom_range(0, 1) == 1);
         s_data  = 8'(vals[idx]);
         chk($sformatf("c3_sr_%0d", cyc), 128'(s_ready), 128'(1));
         step();
         if (s_valid) begin
            exp_flat[idx*8 +: 8] = 8'(vals[idx]);
            idx++;
         end
         chk($sformatf("c3_fill_%0d", cyc), 128'(fill_count), 128'(idx));
         chk($sformatf("c3_tv_%0d", cyc), 128'(tensor_valid), 128'(idx == 16));
         cyc++;
      end
      chk("c3_done", 128'(idx), 128'(16));
      s_valid = 1'b0;
      chk("c3_flat", tensor_flat, exp_flat);
      tensor_ready = 1'b1;
      step();
      tensor_ready = 1'b0;
      chk("c3_drain_fill", 128'(fill_count), 128'(0));

      // Case 4: asynchronous reset mid-fill
      for (int i = 0; i < 7; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h50 + i);
         step();
      end
      chk("c4_fill7", 128'(fill_count), 128'(7));
      s_valid = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("c4_async_sr", 128'(s_ready), 128'(0));
      chk("c4_async_tv", 128'(tensor_valid), 128'(0));
      chk("c4_async_fill", 128'(fill_count), 128'(0));
      chk("c4_async_flat", tensor_flat, 128'(0));
      step();
      rst = 1'b1;
      step();
      chk("c4_release_sr", 128'(s_ready), 128'(1));
      exp_flat = '0;
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h30 + i);
         exp_flat[i*8 +: 8] = 8'(8'h30 + i);
         step();
         if (i == 6) chk("c4_partial_flat", tensor_flat, exp_flat);
      end
      s_valid = 1'b0;
      chk("c4_tv", 128'(tensor_valid), 128'(1));
      chk("c4_flat", tensor_flat, exp_flat);

      // Case 5: back-to-back with tensor_ready held high
      old_flat     = tensor_flat;
      tensor_ready = 1'b1;
      s_valid      = 1'b1;
      hi_cnt  = 0;
      last_hi = -1;
      prev_tv = 1'b1;
      for (int n = 1; n <= 52; n++) begin
         s_data = 8'(n);
         step();
         if (tensor_valid) begin
            hi_cnt++;
            if (last_hi >= 0) chk($sformatf("c5_period_%0d", n), 128'(n - last_hi), 128'(17));
            last_hi = n;
         end
         chk($sformatf("c5_tv_%0d", n), 128'(tensor_valid), 128'((n % 17) == 0));
         if (prev_tv) chk($sformatf("c5_single_%0d", n), 128'(tensor_valid), 128'(0));
         prev_tv = tensor_valid;
      end
      chk("c5_hi_cnt", 128'(hi_cnt), 128'(3));
      s_valid      = 1'b0;
      tensor_ready = 1'b0;
      chk("c5_end_fill", 128'(fill_count), 128'(0));
      chk("c5_end_sr", 128'(s_ready), 128'(1));

`ifdef TENSOR_LAST_CHECK_EN
      // Case 6: early last then a correctly framed tensor
      for (int i = 0; i < 9; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h70 + i);
         s_last  = (i == 8);
         step();
         if (i < 8) chk($sformatf("c6_noerr_%0d", i), 128'(err_last), 128'(0));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("c6_early_err", 128'(err_last), 128'(1));
      chk("c6_early_fill", 128'(fill_count), 128'(0));
      chk("c6_early_tv", 128'(tensor_valid), 128'(0));
      step();
      chk("c6_err_single", 128'(err_last), 128'(0));
      for (int i = 0; i < 16; i++) begin
         s_valid = 1'b1;
         s_data  = 8'(8'h10 + i);
         s_last  = (i == 15);
         step();
         chk($sformatf("c6_good_err_%0d", i), 128'(err_last), 128'(0));
      end
      s_valid = 1'b0;
      s_last  = 1'b0;
      chk("c6_good_tv", 128'(tensor_valid), 128'(1));
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
